fetch_instr_queue: RTL and testbench
====================================

// Module: fetch_instr_queue
// PURPOSE
//   Instruction queue sitting directly downstream of fetch_unit and upstream of dispatch.
//   Captures each valid fetched instr with its PC/nPC into a circular FIFO.
//   Presents the oldest entry to dispatch with a valid/ready handshake.
//   Back-pressures fetch_unit through core_control_stall_fetch_unit when full.
//   Flushes all entries on a ROB restart (take_resolved).
// PARAMETERS
//   IQ_DEPTH      4   number of queue entries; must be a power of 2, >= 2
//   LOG_IQ_DEPTH  2   log2(IQ_DEPTH); pointer index width
// PORTS
//   CLK                          in   1      clock
//   nRST                         in   1      reset, asynchronous, active-low
//   from_fetch_ivalid            in   1      fetch_unit to_pipeline_ivalid
//   from_fetch_instr             in   32     fetch_unit to_pipeline_instr (word_t)
//   from_fetch_PC                in   14     fetch_unit to_pipeline_PC (pc_t)
//   from_fetch_nPC               in   14     fetch_unit to_pipeline_nPC (pc_t)
//   from_pipeline_take_resolved  in   1      ROB restart; flush queue
//   dispatch_ready               in   1      dispatch consumes head this cycle if valid
//   to_fetch_stall               out  1      drives core_control_stall_fetch_unit
//   to_dispatch_valid            out  1      head entry valid
//   to_dispatch_instr            out  32     head instr
//   to_dispatch_PC               out  14     head PC
//   to_dispatch_nPC              out  14     head predicted nPC
//   IQ_count_out                 out  LOG_IQ_DEPTH+1  current occupancy 0..IQ_DEPTH
//   DUT_error                    out  1      registered error flag
// BEHAVIOUR
//   - Storage: IQ_DEPTH entries {instr, PC, nPC}; head/tail pointers LOG_IQ_DEPTH+1 bits wide.
//     Index = low LOG_IQ_DEPTH bits; MSB is the wrap bit.
//   - empty = (head == tail).
//   - full = (head idx == tail idx) & (head wrap != tail wrap).
//   - IQ_count_out = tail - head, modulo 2^(LOG_IQ_DEPTH+1).
//   - Reset values: head = 0, tail = 0, entries = 0, DUT_error = 0.
//     Outputs at reset: valid = 0, stall = 0, count = 0.
//   - to_fetch_stall = full. Combinational from registered pointers only; no path from
//     dispatch_ready. A full queue stalls fetch even if dispatch dequeues the same cycle
//     (1-cycle bubble, accepted).
//   - Enqueue: enq = from_fetch_ivalid & ~full & ~take_resolved.
//     Write at tail idx; tail += 1 at the clock edge.
//   - Dequeue: deq = to_dispatch_valid & dispatch_ready & ~take_resolved; head += 1.
//   - Simultaneous enq & deq (not full, not empty): both occur; count is unchanged.
//   - Enq into an empty queue: entry becomes visible to dispatch the next cycle.
//     Zero-cycle bypass is not allowed.
//   - to_dispatch_valid = ~empty. Head data is driven from the array at head idx
//     (registered storage, combinational read).
//   - Wrap-around: pointers roll over naturally modulo 2^(LOG_IQ_DEPTH+1).
//   - Flush: take_resolved = 1 has priority over enq and deq.
//     Next cycle head = tail = 0 and valid = 0. Entry contents need not be cleared.
//     Fetch ivalid is already 0 during take_resolved; any ivalid then is ignored.
//   - Error: next_DUT_error = from_fetch_ivalid & full & ~take_resolved
//     (fetch ignored the stall). DUT_error is a 1-cycle registered pulse.
//     The instr is dropped and the queue is unchanged.
//   - Reset mid-operation: nRST low immediately clears pointers and DUT_error
//     (asynchronous). Queue is empty on the first edge after release.
//   - No internal state machine beyond the pointers. Halt is handled upstream: fetch_unit
//     stops issuing ivalid; the queue drains normally.
// TESTING
//   1. Fill: ready=0; ivalid 4 cycles with instr A0..A3, PC 0x10..0x13
//      -> count=4, stall=1 after 4th edge; valid=1, head instr=A0, PC=0x10.
//   2. Drain: from full, ivalid=0, ready=1 for 4 cycles
//      -> dispatch sees A0,A1,A2,A3 in order; then valid=0, stall=0, count=0.
//   3. Streaming + wrap: ivalid=1 and ready=1 continuously for 10 cycles, PC 0x20..0x29
//      -> count stays 1 after the first edge; output PCs 0x20..0x29 in order across
//      pointer wrap; no DUT_error.
//   4. Flush: 3 entries held, assert take_resolved with ivalid=1 and ready=1
//      -> next cycle count=0, valid=0, no entry enqueued or dequeued;
//      the next ivalid lands at index 0.
//   5. Overflow error: full queue, ivalid=1 with instr B
//      -> DUT_error=1 for exactly one cycle; contents A0..A3 unchanged; B never dispatched.
//   6. Async reset mid-stream: count=2, drop nRST between edges
//      -> valid=0, count=0, stall=0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/fetch_instr_queue.sv
// Circular instruction queue between fetch_unit and dispatch.
// Holds {instr, PC, nPC}; stalls fetch when full and flushes on ROB restart.
module fetch_instr_queue #(
  parameter int IQ_DEPTH     = 4,
  parameter int LOG_IQ_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    from_fetch_ivalid,
  input  logic [31:0]             from_fetch_instr,
  input  logic [13:0]             from_fetch_PC,
  input  logic [13:0]             from_fetch_nPC,
  input  logic                    from_pipeline_take_resolved,
  input  logic                    dispatch_ready,
  output logic                    to_fetch_stall,
  output logic                    to_dispatch_valid,
  output logic [31:0]             to_dispatch_instr,
  output logic [13:0]             to_dispatch_PC,
  output logic [13:0]             to_dispatch_nPC,
  output logic [LOG_IQ_DEPTH:0]   IQ_count_out,
  output logic                    DUT_error
);

  localparam int PW = LOG_IQ_DEPTH + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  // Handshake: an entry moves to dispatch on a clock edge where
  // to_dispatch_valid & dispatch_ready are both high and no flush is requested;
  // fetch is accepted on an edge where ivalid is high, the queue is not full and
  // no flush is requested.
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [31:0]             instr_q [IQ_DEPTH];
  logic [31:0]             instr_d [IQ_DEPTH];
  logic [13:0]             pc_q    [IQ_DEPTH];
  logic [13:0]             pc_d    [IQ_DEPTH];
  logic [13:0]             npc_q   [IQ_DEPTH];
  logic [13:0]             npc_d   [IQ_DEPTH];
  logic                    err_q, err_d;

  logic [LOG_IQ_DEPTH-1:0] head_idx, tail_idx;
  logic                    empty, full, enq, deq, flush;

  assign head_idx = head_q[LOG_IQ_DEPTH-1:0];
  assign tail_idx = tail_q[LOG_IQ_DEPTH-1:0];
  assign flush    = from_pipeline_take_resolved;
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[PW-1] != tail_q[PW-1]);
  assign enq      = from_fetch_ivalid && !full && !flush;
  assign deq      = to_dispatch_valid && dispatch_ready && !flush;

  // Stall depends only on registered pointers, never on dispatch_ready.
  assign to_fetch_stall    = full;
  assign to_dispatch_valid = !empty;
  assign to_dispatch_instr = instr_q[head_idx];
  assign to_dispatch_PC    = pc_q[head_idx];
  assign to_dispatch_nPC   = npc_q[head_idx];
  assign IQ_count_out      = tail_q - head_q;
  assign DUT_error         = err_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    err_d   = from_fetch_ivalid && full && !flush;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq) begin
        instr_d[tail_idx] = from_fetch_instr;
        pc_d[tail_idx]    = from_fetch_PC;
        npc_d[tail_idx]   = from_fetch_nPC;
        tail_d            = tail_q + PTR_ONE;
      end
      if (deq) begin
        head_d = head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        npc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue: scoreboard of expected dispatch entries
// popped by a monitor, plus direct checks of occupancy, stall and error.
module tb_fetch_instr_queue;

  logic        CLK;
  logic        nRST;
  logic        from_fetch_ivalid;
  logic [31:0] from_fetch_instr;
  logic [13:0] from_fetch_PC;
  logic [13:0] from_fetch_nPC;
  logic        from_pipeline_take_resolved;
  logic        dispatch_ready;
  logic        to_fetch_stall;
  logic        to_dispatch_valid;
  logic [31:0] to_dispatch_instr;
  logic [13:0] to_dispatch_PC;
  logic [13:0] to_dispatch_nPC;
  logic [2:0]  IQ_count_out;
  logic        DUT_error;

  int checks   = 0;
  int failures = 0;
  logic [59:0] exp_q[$];  // {instr, PC, nPC}

  fetch_instr_queue #(.IQ_DEPTH(4), .LOG_IQ_DEPTH(2)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .from_fetch_ivalid(from_fetch_ivalid),
    .from_fetch_instr(from_fetch_instr),
    .from_fetch_PC(from_fetch_PC),
    .from_fetch_nPC(from_fetch_nPC),
    .from_pipeline_take_resolved(from_pipeline_take_resolved),
    .dispatch_ready(dispatch_ready),
    .to_fetch_stall(to_fetch_stall),
    .to_dispatch_valid(to_dispatch_valid),
    .to_dispatch_instr(to_dispatch_instr),
    .to_dispatch_PC(to_dispatch_PC),
    .to_dispatch_nPC(to_dispatch_nPC),
    .IQ_count_out(IQ_count_out),
    .DUT_error(DUT_error)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached, required finish before %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_fetch(input logic v, input logic [31:0] instr, input logic [13:0] pc,
                             input logic expect_accept);
    from_fetch_ivalid = v;
    from_fetch_instr  = instr;
    from_fetch_PC     = pc;
    from_fetch_nPC    = pc + 14'd1;
    if (v && expect_accept) exp_q.push_back({instr, pc, pc + 14'd1});
  endtask

  task automatic idle_fetch();
    from_fetch_ivalid = 1'b0;
    from_fetch_instr  = '0;
    from_fetch_PC     = '0;
    from_fetch_nPC    = '0;
  endtask

  // monitor: a dispatch transfer happens on the coming edge; compare against scoreboard
  always @(negedge CLK) begin
    if (nRST && to_dispatch_valid && dispatch_ready && !from_pipeline_take_resolved) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dispatch_unexpected: actual instr=0x%0h PC=0x%0h required no transfer",
                 to_dispatch_instr, to_dispatch_PC);
      end else begin
        logic [59:0] e;
        e = exp_q.pop_front();
        if ({to_dispatch_instr, to_dispatch_PC, to_dispatch_nPC} !== e) begin
          failures++;
          $display("FAIL dispatch_entry: actual instr=0x%0h PC=0x%0h nPC=0x%0h required instr=0x%0h PC=0x%0h nPC=0x%0h",
                   to_dispatch_instr, to_dispatch_PC, to_dispatch_nPC, e[59:28], e[27:14], e[13:0]);
        end
      end
    end
  end

  initial begin
    nRST = 1'b0;
    idle_fetch();
    from_pipeline_take_resolved = 1'b0;
    dispatch_ready = 1'b0;
    #12;
    check("reset_valid", 32'(to_dispatch_valid), 32'd0);
    check("reset_count", 32'(IQ_count_out), 32'd0);
    check("reset_stall", 32'(to_fetch_stall), 32'd0);
    check("reset_error", 32'(DUT_error), 32'd0);
    cycle();
    nRST = 1'b1;
    cycle();

    // fill
    for (int i = 0; i < 4; i++) begin
      drive_fetch(1'b1, 32'hA000_0000 + 32'(i), 14'h010 + 14'(i), 1'b1);
      cycle();
      check("fill_count", 32'(IQ_count_out), 32'(i + 1));
    end
    idle_fetch();
    check("fill_stall", 32'(to_fetch_stall), 32'd1);
    check("fill_valid", 32'(to_dispatch_valid), 32'd1);
    check("fill_head_instr", to_dispatch_instr, 32'hA000_0000);
    check("fill_head_pc", 32'(to_dispatch_PC), 32'h10);

    // overflow: B must be dropped
    drive_fetch(1'b1, 32'hB000_000B, 14'h0BB, 1'b0);
    cycle();
    idle_fetch();
    check("ovf_error_pulse", 32'(DUT_error), 32'd1);
    check("ovf_count", 32'(IQ_count_out), 32'd4);
    cycle();
    check("ovf_error_clear", 32'(DUT_error), 32'd0);
    check("ovf_head_instr", to_dispatch_instr, 32'hA000_0000);

    // drain
    dispatch_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    dispatch_ready = 1'b0;
    check("drain_valid", 32'(to_dispatch_valid), 32'd0);
    check("drain_stall", 32'(to_fetch_stall), 32'd0);
    check("drain_count", 32'(IQ_count_out), 32'd0);
    check("drain_all_seen", 32'(exp_q.size()), 32'd0);

    // streaming across pointer wrap
    dispatch_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_fetch(1'b1, 32'hC000_0000 + 32'(i), 14'h020 + 14'(i), 1'b1);
      cycle();
      check("stream_count", 32'(IQ_count_out), 32'd1);
      check("stream_error", 32'(DUT_error), 32'd0);
    end
    idle_fetch();
    cycle();
    dispatch_ready = 1'b0;
    check("stream_end_count", 32'(IQ_count_out), 32'd0);
    check("stream_all_seen", 32'(exp_q.size()), 32'd0);

    // flush with 3 entries held
    for (int i = 0; i < 3; i++) begin
      drive_fetch(1'b1, 32'hD000_0000 + 32'(i), 14'h030 + 14'(i), 1'b1);
      cycle();
    end
    check("preflush_count", 32'(IQ_count_out), 32'd3);
    drive_fetch(1'b1, 32'hDEAD_0000, 14'h3FF, 1'b0);
    from_pipeline_take_resolved = 1'b1;
    dispatch_ready = 1'b1;
    exp_q.delete();
    cycle();
    from_pipeline_take_resolved = 1'b0;
    dispatch_ready = 1'b0;
    idle_fetch();
    check("flush_count", 32'(IQ_count_out), 32'd0);
    check("flush_valid", 32'(to_dispatch_valid), 32'd0);
    check("flush_error", 32'(DUT_error), 32'd0);
    drive_fetch(1'b1, 32'hE000_0000, 14'h040, 1'b1);
    cycle();
    idle_fetch();
    check("postflush_count", 32'(IQ_count_out), 32'd1);
    check("postflush_pc", 32'(to_dispatch_PC), 32'h40);
    check("postflush_index0", 32'(dut.pc_q[0]), 32'h40);
    dispatch_ready = 1'b1;
    cycle();
    dispatch_ready = 1'b0;
    check("postflush_drained", 32'(IQ_count_out), 32'd0);

    // async reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive_fetch(1'b1, 32'hF000_0000 + 32'(i), 14'h050 + 14'(i), 1'b1);
      cycle();
    end
    idle_fetch();
    check("prereset_count", 32'(IQ_count_out), 32'd2);
    #2;
    nRST = 1'b0;
    exp_q.delete();
    #1;
    check("areset_valid", 32'(to_dispatch_valid), 32'd0);
    check("areset_count", 32'(IQ_count_out), 32'd0);
    check("areset_stall", 32'(to_fetch_stall), 32'd0);
    cycle();
    nRST = 1'b1;
    drive_fetch(1'b1, 32'h1234_5678, 14'h060, 1'b1);
    cycle();
    idle_fetch();
    check("resume_count", 32'(IQ_count_out), 32'd1);
    dispatch_ready = 1'b1;
    cycle();
    dispatch_ready = 1'b0;
    check("resume_drained", 32'(IQ_count_out), 32'd0);
    check("final_all_seen", 32'(exp_q.size()), 32'd0);

    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
